// File: rtl/guesser_pkg.sv
// guesser_pkg: shared widths, limits and FSM state encoding for auto_guesser
package guesser_pkg;
  localparam int GUESS_W          = 8;
  localparam int ATT_W            = 4;
  localparam int MAX_ATTEMPTS     = 9;
  localparam int RESP_LAT_DEFAULT = 3;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GUESS = 3'd1,
    S_WAIT  = 3'd2,
    S_EVAL  = 3'd3,
    S_DONE  = 3'd4,
    S_FAIL  = 3'd5
  } state_e;
endpackage

// File: rtl/auto_guesser_resp_timer.sv
// resp_timer: loadable down-counter timing the oracle response latency
module resp_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_val,
  output logic       expired,
  output logic       expiring
);
  logic [3:0] cnt_q, cnt_d;
  // load wins over decrement; the counter rests at zero
  always_comb begin
    cnt_d = load ? load_val : (dec && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
  end
  // count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= 4'd0;
    else       cnt_q <= cnt_d;
  end
  assign expired  = cnt_q == 4'd0;
  assign expiring = dec && cnt_q == 4'd1;
endmodule

// File: rtl/auto_guesser.sv
// auto_guesser: binary-search FSM that finds an oracle's secret byte
module auto_guesser
  import guesser_pkg::*;
#(
  parameter int RESP_LAT = RESP_LAT_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  output logic [GUESS_W-1:0] o_guess,
  output logic               o_enter,
  input  logic               i_over,
  input  logic               i_under,
  input  logic               i_equal,
  output logic               o_done,
  output logic               o_error,
  output logic [GUESS_W-1:0] o_found,
  output logic [ATT_W-1:0]   o_attempts
);
  state_e             state_q, state_d;
  logic [GUESS_W-1:0] lo_q, lo_d, hi_q, hi_d, guess_q, guess_d, found_q, found_d;
  logic [ATT_W-1:0]   att_q, att_d;
  logic [GUESS_W:0]   sum;
  logic [GUESS_W-1:0] mid;
  logic [1:0]         nflags;
  logic               load, dec, expired, expiring;
  assign sum    = {1'b0, lo_q} + {1'b0, hi_q};
  assign mid    = sum[GUESS_W:1];
  assign nflags = {1'b0, i_over} + {1'b0, i_under} + {1'b0, i_equal};
  resp_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .dec      (dec),
    .load_val (4'(RESP_LAT)),
    .expired  (expired),
    .expiring (expiring)
  );
  // next-state and datapath updates; exactly one flag must be asserted at evaluation
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    guess_d = guess_q;
    att_d   = att_q;
    found_d = found_q;
    load    = 1'b0;
    dec     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: if (i_start) begin
        lo_d    = '0;
        hi_d    = '1;
        att_d   = '0;
        state_d = S_GUESS;
      end
      S_GUESS: begin
        guess_d = mid;
        att_d   = (att_q == '1) ? att_q : att_q + 1'b1;
        load    = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        dec     = 1'b1;
        state_d = (expiring || expired) ? S_EVAL : S_WAIT;
      end
      S_EVAL: begin
        if (nflags != 2'd1) state_d = S_FAIL;
        else if (i_equal) begin
          found_d = guess_q;
          state_d = S_DONE;
        end
        else if (att_q >= ATT_W'(MAX_ATTEMPTS)) state_d = S_FAIL;
        else if (i_over) begin
          hi_d    = guess_q - 1'b1;
          state_d = (guess_q == lo_q) ? S_FAIL : S_GUESS;
        end
        else begin
          lo_d    = guess_q + 1'b1;
          state_d = (guess_q == hi_q) ? S_FAIL : S_GUESS;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      lo_q    <= '0;
      hi_q    <= '1;
      guess_q <= '0;
      att_q   <= '0;
      found_q <= '0;
    end
    else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      guess_q <= guess_d;
      att_q   <= att_d;
      found_q <= found_d;
    end
  end
  assign o_enter    = state_q == S_GUESS;
  assign o_guess    = o_enter ? mid : guess_q;
  assign o_done     = state_q == S_DONE;
  assign o_error    = state_q == S_FAIL;
  assign o_found    = found_q;
  assign o_attempts = att_q;
endmodule
